clock_alarm_multi: RTL and testbench
====================================

# clock_alarm_multi

Parametrised multi-alarm 24-hour clock, the next generation of the single-alarm clock core that sits behind the Tiny Tapeout top-level wrapper. It keeps hours:minutes from a prescaled system clock and holds NUM_ALARMS independently programmable alarm slots. A ring state machine adds snooze, acknowledge and auto-timeout. The wrapper maps its pins onto ui/uo/uio exactly as it does for the existing core.

## Interface

- TICKS_PER_MIN, default 60: clk cycles per minute (≥2); prescaler width = clog2(TICKS_PER_MIN).
- NUM_ALARMS, default 4: alarm slots (≥1); AW = max(1, clog2(NUM_ALARMS)).
- SNOOZE_MIN, default 5: snooze length in minutes (1..63).
- RING_MIN, default 10: minutes of unattended ringing before auto-stop (1..63).

Ports:

- clk  in  1  system clock; one clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  count enable; 0 freezes the prescaler (time and snooze/ring timers freeze).
- time_we  in  1  load time_hours/time_minutes.
- time_hours  in  5  time to load, 0..23.
- time_minutes  in  6  time to load, 0..59.
- alm_we  in  1  write alarm slot alm_sel.
- alm_sel  in  AW  slot index.
- alm_hours  in  5  alarm hour, 0..23.
- alm_minutes  in  6  alarm minute, 0..59.
- alm_en  in  1  slot enable written with the slot.
- snooze  in  1  snooze request (level sampled each cycle).
- ack  in  1  dismiss request.
- hours  out  5  current hour.
- minutes  out  6  current minute.
- minute_tick  out  1  one-cycle pulse on each counted minute rollover.
- alarm  out  1  high in RINGING.
- snoozed  out  1  high in SNOOZED.
- alarm_id  out  AW  slot that caused the current ring/snooze.
- wr_err  out  1  one-cycle pulse on a rejected write.

## Operation

- Reset: time 00:00, prescaler 0, all slots 00:00 disabled, FSM IDLE, all outputs 0.
- Prescaler counts 0..TICKS_PER_MIN-1 while ena=1. At terminal count it wraps to 0 and minutes advance: 59→0 with hours +1, 23:59→00:00. minute_tick and the internal chk flag are registered with the time update.
- time_we: loads the time and clears the prescaler. It has priority over a same-cycle rollover, which is then dropped (no tick, no chk). Loading never triggers an alarm.
- alm_we: writes hours, minutes and enable to slot alm_sel. Rejected (slot unchanged, wr_err pulse) if hours>23, minutes>59 or alm_sel≥NUM_ALARMS. Same rules for time_we, which also pulses wr_err on rejection.
- Match: in a cycle with chk=1, each enabled slot is compared with the current time. The lowest matching index wins.
- FSM states IDLE, RINGING, SNOOZED.
  - IDLE→RINGING on match: alarm_id latched, ring_cnt cleared.
  - RINGING: ack→IDLE. snooze→SNOOZED with snz_cnt=SNOOZE_MIN. Each minute_tick increments ring_cnt; reaching RING_MIN returns to IDLE.
  - SNOOZED: each minute_tick decrements snz_cnt; at 0 the FSM goes to RINGING with ring_cnt cleared. ack→IDLE.
  - Precedence per cycle: ack > snooze > timer events. snooze in SNOOZED is ignored.
  - Matches while RINGING/SNOOZED are ignored; alarm_id is unchanged.
  - An alm_we that disables, or reprograms, the slot equal to alarm_id while RINGING/SNOOZED forces IDLE next cycle.
- alarm_id holds its last value in IDLE.

## Timing

- Cycle N: prescaler at terminal with ena=1. Edge ending N updates time, sets minute_tick=1 and chk=1 (visible N+1).
- Cycle N+1: compare. Edge ending N+1 enters RINGING, so alarm=1 in N+2.
- ack/snooze sampled in cycle K take effect at the edge ending K (outputs change in K+1).
- Writes take effect at the edge ending the write cycle; wr_err is high in the following cycle only.
- Asynchronous reset mid-ring or mid-snooze clears outputs immediately, independent of clk.

## Test plan

Bench parameters: TICKS_PER_MIN=4, NUM_ALARMS=4, SNOOZE_MIN=2, RING_MIN=3.

- Rollover: load 23:59, run 4 cycles with ena=1 → hours=0, minutes=0, one minute_tick pulse; with ena=0 for 20 cycles, time stays unchanged.
- Match priority: slots 1 and 3 both at 07:00 enabled; load 06:59; after the tick → alarm=1 two cycles later, alarm_id=1.
- Snooze: ringing, pulse snooze → snoozed=1, alarm=0; after 2 minute_ticks → alarm=1 again; ack → both 0.
- Timeout: ringing with no input → alarm drops after the third minute_tick; a match on slot 2 during the ring is ignored.
- Write rules: alm_we with hours=24 → wr_err pulse, slot unchanged. time_we coincident with terminal count → loaded value held, no minute_tick. Loading a time equal to an enabled alarm → no ring.
- Cancel/reset: disable the ringing slot via alm_we → IDLE next cycle. Assert rst_n=0 while snoozed → all outputs 0 immediately, time 00:00.

Source files
------------

// File: rtl/clock_alarm_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_alarm_multi
// Brief    : 24-hour hh:mm clock with NUM_ALARMS programmable alarm slots and
//            a ring/snooze/acknowledge state machine with ring auto-timeout.
// Revision : 1.0 - initial release
// ============================================================================
module clock_alarm_multi #(
    parameter int TICKS_PER_MIN = 60,
    parameter int NUM_ALARMS    = 4,
    parameter int SNOOZE_MIN    = 5,
    parameter int RING_MIN      = 10,
    localparam int AW           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          time_we,
    input  logic [4:0]    time_hours,
    input  logic [5:0]    time_minutes,
    input  logic          alm_we,
    input  logic [AW-1:0] alm_sel,
    input  logic [4:0]    alm_hours,
    input  logic [5:0]    alm_minutes,
    input  logic          alm_en,
    input  logic          snooze,
    input  logic          ack,
    output logic [4:0]    hours,
    output logic [5:0]    minutes,
    output logic          minute_tick,
    output logic          alarm,
    output logic          snoozed,
    output logic [AW-1:0] alarm_id,
    output logic          wr_err
);

    localparam int PW  = $clog2(TICKS_PER_MIN);
    localparam int AW1 = AW + 1;

    localparam logic [PW-1:0] c_presc_last = PW'(TICKS_PER_MIN - 1);
    localparam logic [AW:0]   c_num_alarms = AW1'(NUM_ALARMS);
    localparam logic [5:0]    c_snooze_min = 6'(SNOOZE_MIN);
    localparam logic [5:0]    c_ring_min   = 6'(RING_MIN);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_ringing = 2'd1;
    localparam logic [1:0] c_st_snoozed = 2'd2;

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic          tick_q, tick_d;
    logic          wr_err_q, wr_err_d;
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] alarm_id_q, alarm_id_d;
    logic [5:0]    ring_cnt_q, ring_cnt_d;
    logic [5:0]    snz_cnt_q, snz_cnt_d;

    logic [4:0]            alm_h_q  [NUM_ALARMS];
    logic [4:0]            alm_h_d  [NUM_ALARMS];
    logic [5:0]            alm_m_q  [NUM_ALARMS];
    logic [5:0]            alm_m_d  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alm_en_q, alm_en_d;

    logic                  time_load, alm_load, cancel;
    logic [NUM_ALARMS-1:0] slot_hit;
    logic                  any_hit;
    logic [AW-1:0]         hit_id;

    always_comb begin
        time_load = time_we && (time_hours <= 5'd23) && (time_minutes <= 6'd59);
        alm_load  = alm_we && (alm_hours <= 5'd23) && (alm_minutes <= 6'd59)
                    && ({1'b0, alm_sel} < c_num_alarms);
        wr_err_d  = (time_we && !time_load) || (alm_we && !alm_load);
        cancel    = alm_load && (alm_sel == alarm_id_q) && (state_q != c_st_idle);
    end

    // tick_q doubles as the compare strobe: both are registered with the time update.
    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot_hit
        assign slot_hit[g] = alm_en_q[g] && (alm_h_q[g] == hours_q)
                             && (alm_m_q[g] == minutes_q);
    end

    always_comb begin
        any_hit = |slot_hit;
        hit_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_hit[i]) hit_id = AW'(i);
        end
    end

    // A valid time load wins over a coincident rollover, which is dropped.
    always_comb begin
        presc_d   = presc_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        tick_d    = 1'b0;
        if (time_load) begin
            hours_d   = time_hours;
            minutes_d = time_minutes;
            presc_d   = '0;
        end else if (ena) begin
            if (presc_q == c_presc_last) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (minutes_q == 6'd59) begin
                    minutes_d = 6'd0;
                    hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_comb begin
        alm_en_d = alm_en_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            alm_h_d[i] = alm_h_q[i];
            alm_m_d[i] = alm_m_q[i];
            if (alm_load && (alm_sel == AW'(i))) begin
                alm_h_d[i]  = alm_hours;
                alm_m_d[i]  = alm_minutes;
                alm_en_d[i] = alm_en;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        alarm_id_d = alarm_id_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        case (state_q)
            c_st_idle: begin
                if (tick_q && any_hit) begin
                    state_d    = c_st_ringing;
                    alarm_id_d = hit_id;
                    ring_cnt_d = 6'd0;
                end
            end
            c_st_ringing: begin
                if (ack) begin
                    state_d = c_st_idle;
                end else if (snooze) begin
                    state_d   = c_st_snoozed;
                    snz_cnt_d = c_snooze_min;
                end else if (tick_q) begin
                    ring_cnt_d = ring_cnt_q + 6'd1;
                    if (ring_cnt_q + 6'd1 == c_ring_min) state_d = c_st_idle;
                end
            end
            c_st_snoozed: begin
                if (ack) begin
                    state_d = c_st_idle;
                end else if (tick_q) begin
                    snz_cnt_d = snz_cnt_q - 6'd1;
                    if (snz_cnt_q == 6'd1) begin
                        state_d    = c_st_ringing;
                        ring_cnt_d = 6'd0;
                    end
                end
            end
            default: state_d = c_st_idle;
        endcase
        if (cancel) state_d = c_st_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            hours_q    <= 5'd0;
            minutes_q  <= 6'd0;
            tick_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            state_q    <= c_st_idle;
            alarm_id_q <= '0;
            ring_cnt_q <= 6'd0;
            snz_cnt_q  <= 6'd0;
            alm_h_q    <= '{default: 5'd0};
            alm_m_q    <= '{default: 6'd0};
            alm_en_q   <= '0;
        end else begin
            presc_q    <= presc_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            tick_q     <= tick_d;
            wr_err_q   <= wr_err_d;
            state_q    <= state_d;
            alarm_id_q <= alarm_id_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            alm_h_q    <= alm_h_d;
            alm_m_q    <= alm_m_d;
            alm_en_q   <= alm_en_d;
        end
    end

    assign hours       = hours_q;
    assign minutes     = minutes_q;
    assign minute_tick = tick_q;
    assign alarm       = (state_q == c_st_ringing);
    assign snoozed     = (state_q == c_st_snoozed);
    assign alarm_id    = alarm_id_q;
    assign wr_err      = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_alarm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_alarm_multi
// Brief    : Directed and random stimulus for clock_alarm_multi, checked every
//            cycle against a minute-of-day reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_alarm_multi;

    localparam int TPM = 4;
    localparam int NA  = 4;
    localparam int SNZ = 2;
    localparam int RNG = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0, time_we = 1'b0, alm_we = 1'b0, alm_en = 1'b0;
    logic       snooze = 1'b0, ack = 1'b0;
    logic [4:0] time_hours = '0, alm_hours = '0;
    logic [5:0] time_minutes = '0, alm_minutes = '0;
    logic [1:0] alm_sel = '0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic       minute_tick, alarm, snoozed, wr_err;
    logic [1:0] alarm_id;

    clock_alarm_multi #(
        .TICKS_PER_MIN(TPM), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_MIN(RNG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .time_we(time_we), .time_hours(time_hours), .time_minutes(time_minutes),
        .alm_we(alm_we), .alm_sel(alm_sel), .alm_hours(alm_hours),
        .alm_minutes(alm_minutes), .alm_en(alm_en),
        .snooze(snooze), .ack(ack),
        .hours(hours), .minutes(minutes), .minute_tick(minute_tick),
        .alarm(alarm), .snoozed(snoozed), .alarm_id(alarm_id), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: time as minute-of-day, alarm as minute counts.
    typedef enum int {M_IDLE, M_RING, M_SNZ} mode_t;
    int    m_tod, m_presc, m_id, m_ring, m_snz;
    bit    m_tick, m_werr;
    mode_t m_mode;
    int    m_ah [NA];
    int    m_am [NA];
    bit    m_en [NA];

    task automatic model_reset();
        m_tod = 0; m_presc = 0; m_id = 0; m_ring = 0; m_snz = 0;
        m_tick = 0; m_werr = 0; m_mode = M_IDLE;
        for (int i = 0; i < NA; i++) begin
            m_ah[i] = 0; m_am[i] = 0; m_en[i] = 0;
        end
    endtask

    task automatic model_step();
        mode_t n_mode;
        int    n_id, n_ring, n_snz, n_tod, n_presc, hit;
        bit    n_tick, n_werr, cancel;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n_mode = m_mode; n_id = m_id; n_ring = m_ring; n_snz = m_snz;
        n_tod = m_tod; n_presc = m_presc; n_tick = 0; n_werr = 0; cancel = 0;
        hit = -1;
        if (m_tick)
            for (int i = 0; i < NA; i++)
                if (hit < 0 && m_en[i] && (m_ah[i] * 60 + m_am[i] == m_tod)) hit = i;
        case (m_mode)
            M_IDLE: if (hit >= 0) begin n_mode = M_RING; n_id = hit; n_ring = 0; end
            M_RING: begin
                if (ack) n_mode = M_IDLE;
                else if (snooze) begin n_mode = M_SNZ; n_snz = SNZ; end
                else if (m_tick) begin
                    n_ring = m_ring + 1;
                    if (n_ring >= RNG) n_mode = M_IDLE;
                end
            end
            default: begin
                if (ack) n_mode = M_IDLE;
                else if (m_tick) begin
                    n_snz = m_snz - 1;
                    if (n_snz == 0) begin n_mode = M_RING; n_ring = 0; end
                end
            end
        endcase
        if (time_we && time_hours < 24 && time_minutes < 60) begin
            n_tod = time_hours * 60 + time_minutes;
            n_presc = 0;
        end else begin
            if (time_we) n_werr = 1;
            if (ena) begin
                if (m_presc == TPM - 1) begin
                    n_presc = 0; n_tod = (m_tod + 1) % 1440; n_tick = 1;
                end else n_presc = m_presc + 1;
            end
        end
        if (alm_we) begin
            if (alm_hours < 24 && alm_minutes < 60 && alm_sel < NA) begin
                if (m_mode != M_IDLE && alm_sel == m_id) cancel = 1;
                m_ah[alm_sel] = alm_hours;
                m_am[alm_sel] = alm_minutes;
                m_en[alm_sel] = alm_en;
            end else n_werr = 1;
        end
        if (cancel) n_mode = M_IDLE;
        m_mode = n_mode; m_id = n_id; m_ring = n_ring; m_snz = n_snz;
        m_tod = n_tod; m_presc = n_presc; m_tick = n_tick; m_werr = n_werr;
    endtask

    task automatic compare_all();
        check_eq("hours", 32'(hours), m_tod / 60);
        check_eq("minutes", 32'(minutes), m_tod % 60);
        check_eq("minute_tick", 32'(minute_tick), 32'(m_tick));
        check_eq("alarm", 32'(alarm), 32'(m_mode == M_RING));
        check_eq("snoozed", 32'(snoozed), 32'(m_mode == M_SNZ));
        check_eq("alarm_id", 32'(alarm_id), m_id);
        check_eq("wr_err", 32'(wr_err), 32'(m_werr));
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_alarm(input int sel, input int h, input int m, input bit en);
        alm_we = 1'b1; alm_sel = sel[1:0]; alm_hours = h[4:0];
        alm_minutes = m[5:0]; alm_en = en;
        cycle();
        alm_we = 1'b0;
    endtask

    task automatic load_time(input int h, input int m);
        time_we = 1'b1; time_hours = h[4:0]; time_minutes = m[5:0];
        cycle();
        time_we = 1'b0;
    endtask

    task automatic wait_ring(input string tag, input int bound, output int ticks);
        bit seen = 0;
        ticks = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            cycle();
            if (alarm === 1'b1) seen = 1;
            else if (minute_tick === 1'b1) ticks++;
        end
        check_eq(tag, 32'(seen), 1);
    endtask

    task automatic wait_drop(input string tag, input int bound, output int ticks);
        bit seen = 0;
        ticks = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            cycle();
            if (alarm !== 1'b1) seen = 1;
            else if (minute_tick === 1'b1) ticks++;
        end
        check_eq(tag, 32'(seen), 1);
    endtask

    initial begin
        int nt, guard;
        model_reset();
        cycle();
        cycle();
        check_eq("rst_hours", 32'(hours), 0);
        check_eq("rst_alarm", 32'({alarm, snoozed, minute_tick, wr_err, alarm_id}), 0);
        rst_n = 1'b1;

        // Rollover 23:59 -> 00:00, then frozen with ena low
        load_time(23, 59);
        ena = 1'b1;
        nt = 0;
        for (int i = 0; i < TPM; i++) begin
            cycle();
            if (minute_tick === 1'b1) nt++;
        end
        check_eq("roll_time", 32'({hours, minutes}), 0);
        check_eq("roll_ticks", nt, 1);
        ena = 1'b0;
        repeat (20) cycle();
        check_eq("frozen_time", 32'({hours, minutes}), 0);

        // Match priority: slots 1 and 3 both at 07:00
        write_alarm(1, 7, 0, 1'b1);
        write_alarm(3, 7, 0, 1'b1);
        load_time(6, 59);
        ena = 1'b1;
        repeat (TPM) cycle();
        check_eq("prio_tick", 32'(minute_tick), 1);
        check_eq("prio_not_yet", 32'(alarm), 0);
        cycle();
        check_eq("prio_alarm", 32'(alarm), 1);
        check_eq("prio_id", 32'(alarm_id), 1);

        // Snooze for two minute ticks, then acknowledge
        snooze = 1'b1;
        cycle();
        snooze = 1'b0;
        check_eq("snz_state", 32'({snoozed, alarm}), 32'b10);
        wait_ring("snz_rering", 20, nt);
        check_eq("snz_ticks", nt, SNZ);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        check_eq("ack_state", 32'({snoozed, alarm}), 0);

        // Timeout, with slot 2 matching mid-ring
        write_alarm(2, 7, 1, 1'b1);
        load_time(6, 59);
        wait_ring("to_ring", 20, nt);
        wait_drop("to_drop", 40, nt);
        check_eq("to_ticks", nt, RNG);
        check_eq("to_id", 32'(alarm_id), 1);

        // Write rules
        write_alarm(0, 8, 0, 1'b1);
        write_alarm(0, 24, 0, 1'b0);
        check_eq("werr_pulse", 32'(wr_err), 1);
        cycle();
        check_eq("werr_clear", 32'(wr_err), 0);
        load_time(7, 59);
        wait_ring("kept_ring", 20, nt);
        check_eq("kept_id", 32'(alarm_id), 0);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        guard = 0;
        while (m_presc != TPM - 1 && guard < 10) begin
            cycle();
            guard++;
        end
        load_time(10, 30);
        check_eq("load_wins", 32'({hours, minutes, minute_tick}), 32'({5'd10, 6'd30, 1'b0}));
        load_time(12, 60);
        check_eq("bad_time_err", 32'(wr_err), 1);
        check_eq("bad_time_kept", 32'(hours), 10);
        load_time(8, 0);
        repeat (TPM - 1) cycle();
        check_eq("load_no_ring", 32'(alarm), 0);

        // Cancel the ringing slot, then reset while snoozed
        load_time(7, 59);
        wait_ring("cancel_ring", 20, nt);
        write_alarm(0, 8, 0, 1'b0);
        check_eq("cancel_idle", 32'(alarm), 0);
        write_alarm(0, 8, 0, 1'b1);
        load_time(7, 59);
        wait_ring("rst_ring", 20, nt);
        snooze = 1'b1;
        cycle();
        snooze = 1'b0;
        check_eq("rst_snoozed", 32'(snoozed), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_outs", 32'({alarm, snoozed, minute_tick, wr_err, alarm_id}), 0);
        check_eq("async_time", 32'({hours, minutes}), 0);
        model_reset();
        cycle();
        rst_n = 1'b1;

        // Random phase; alarm times placed a few minutes ahead to provoke rings
        for (int c = 0; c < 800; c++) begin
            int t;
            t = (m_tod + int'($urandom_range(1, 3))) % 1440;
            ena    = ($urandom_range(0, 9) != 0);
            snooze = ($urandom_range(0, 11) == 0);
            ack    = ($urandom_range(0, 19) == 0);
            alm_we = ($urandom_range(0, 9) == 0);
            alm_sel = 2'($urandom_range(0, 3));
            alm_hours = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'(t / 60);
            alm_minutes = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'(t % 60);
            alm_en = ($urandom_range(0, 4) != 0);
            time_we = ($urandom_range(0, 39) == 0);
            time_hours = 5'($urandom_range(0, 24));
            time_minutes = 6'($urandom_range(0, 61));
            cycle();
        end
        {ena, snooze, ack, alm_we, time_we} = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
